fx_sub_pipe: RTL and testbench

//  Pipelined signed fixed-point subtractor: o = a - b, with elastic valid/ready flow control.

---
 rtl/fx_pkg.sv | 43 ++++
 rtl/fx_pipe_stage.sv | 42 ++++
 rtl/fx_sub_pipe.sv | 117 +++++++++++
 tb/tb_fx_sub_pipe.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fx_pkg.sv
// Shared fixed-point helpers for the fx_* datapaths.
//   fx_fmt_t   : word format descriptor (total width, fractional bits)
//   fx_rq_t    : requantization result {ovf, data}
//   fx_requant : arithmetic shift right (floor toward -inf), range check
//                against a signed out_w-bit word, optional clamp.
// The value is carried at FX_MAX_W bits so the function serves any format
// up to that width; callers keep the low out_w bits of .data.
package fx_pkg;

  localparam int FX_MAX_W = 64;

  typedef struct packed {
    logic [7:0] width;
    logic [7:0] frac;
  } fx_fmt_t;

  typedef struct packed {
    logic                       ovf;
    logic signed [FX_MAX_W-1:0] data;
  } fx_rq_t;

  function automatic fx_rq_t fx_requant(
    input logic signed [FX_MAX_W-1:0] value,
    input int unsigned                shift,
    input int unsigned                out_w,
    input logic                       sat
  );
    fx_rq_t                     res;
    logic signed [FX_MAX_W-1:0] shifted;
    logic signed [FX_MAX_W-1:0] max_v;
    logic signed [FX_MAX_W-1:0] min_v;
    shifted  = value >>> shift;
    max_v    = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    min_v    = -(64'sd1 <<< (out_w - 1));
    res.ovf  = (shifted > max_v) || (shifted < min_v);
    res.data = shifted;
    if (sat && res.ovf) begin
      res.data = shifted[FX_MAX_W-1] ? min_v : max_v;
    end
    return res;
  endfunction

endpackage

// File: rtl/fx_pipe_stage.sv
// One elastic register stage (valid/ready on both sides).
//   i_clk, i_rst_n     : clock, async active-low reset
//   i_valid, o_ready   : upstream handshake
//   i_data  [W-1:0]    : upstream payload
//   o_valid, i_ready   : downstream handshake
//   o_data  [W-1:0]    : registered payload
// The stage accepts whenever it is empty or its content leaves this cycle,
// so a chain of these sustains one transfer per cycle. Payload is only
// captured for valid input, keeping don't-care data out of the pipe.
module fx_pipe_stage #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  logic         r_valid;
  logic [W-1:0] r_data;

  assign o_ready = ~r_valid | i_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (o_ready) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_data <= i_data;
      end
    end
  end

endmodule

// File: rtl/fx_sub_pipe.sv
// Pipelined signed fixed-point subtractor o = a - b with elastic flow control.
//   i_clk, i_rst_n        : clock, async active-low reset
//   i_valid, o_ready      : operand handshake
//   i_data_1 / i_data_2   : minuend a / subtrahend b, IN_W.IN_FRAC signed
//   o_valid, i_ready      : result handshake
//   o_data                : result, OUT_W.OUT_FRAC signed
//   o_ovf                 : result left the output range (qualified by o_valid)
//   o_ovf_cnt             : saturating count of transferred results with o_ovf
//   i_cnt_clr             : synchronous counter clear (wins over increment)
// Build option FX_SUB_SAT_EN: clamp o_data on overflow; otherwise wrap.
// The subtract and requantize happen in front of stage 0; stages 1..LAT-1
// only delay.
module fx_sub_pipe
  import fx_pkg::*;
#(
  parameter int IN_W     = 15,
  parameter int IN_FRAC  = 8,
  parameter int OUT_W    = 12,
  parameter int OUT_FRAC = 6,
  parameter int LAT      = 2,
  parameter int CNT_W    = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [IN_W-1:0]   i_data_1,
  input  logic [IN_W-1:0]   i_data_2,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [OUT_W-1:0]  o_data,
  output logic              o_ovf,
  output logic [CNT_W-1:0]  o_ovf_cnt,
  input  logic              i_cnt_clr
);

  localparam fx_fmt_t     IN_FMT  = '{width: 8'(IN_W),  frac: 8'(IN_FRAC)};
  localparam fx_fmt_t     OUT_FMT = '{width: 8'(OUT_W), frac: 8'(OUT_FRAC)};
  localparam int unsigned SHIFT   = int'(IN_FMT.frac) - int'(OUT_FMT.frac);
  localparam int unsigned OUT_WU  = int'(OUT_FMT.width);
  localparam int          P_W     = OUT_W + 1;

`ifdef FX_SUB_SAT_EN
  localparam logic SAT_EN = 1'b1;
`else
  localparam logic SAT_EN = 1'b0;
`endif

  // Holds o_ready low until the first clock after reset release.
  logic r_rst_done;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rst_done <= 1'b0;
    end else begin
      r_rst_done <= 1'b1;
    end
  end

  // One extra bit makes the difference exact for any pair of inputs.
  logic signed [IN_W:0]   w_a_ext;
  logic signed [IN_W:0]   w_b_ext;
  logic signed [IN_W:0]   w_diff;
  fx_rq_t                 w_rq;
  logic [OUT_W-1:0]       w_q_data;

  assign w_a_ext  = {i_data_1[IN_W-1], i_data_1};
  assign w_b_ext  = {i_data_2[IN_W-1], i_data_2};
  assign w_diff   = w_a_ext - w_b_ext;
  assign w_rq     = fx_requant(FX_MAX_W'(w_diff), SHIFT, OUT_WU, SAT_EN);
  assign w_q_data = OUT_W'(w_rq.data);

  logic           w_vld [LAT+1];
  logic           w_rdy [LAT+1];
  logic [P_W-1:0] w_dat [LAT+1];

  assign w_vld[0]   = i_valid & r_rst_done;
  assign w_dat[0]   = {w_rq.ovf, w_q_data};
  assign w_rdy[LAT] = i_ready;
  assign o_ready    = w_rdy[0] & r_rst_done;

  for (genvar k = 0; k < LAT; k++) begin : g_stage
    fx_pipe_stage #(
      .W (P_W)
    ) u_stage (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_valid (w_vld[k]),
      .o_ready (w_rdy[k]),
      .i_data  (w_dat[k]),
      .o_valid (w_vld[k+1]),
      .i_ready (w_rdy[k+1]),
      .o_data  (w_dat[k+1])
    );
  end

  assign o_valid = w_vld[LAT];
  assign o_data  = w_dat[LAT][OUT_W-1:0];
  assign o_ovf   = w_dat[LAT][OUT_W];

  logic             w_out_xfer;
  logic [CNT_W-1:0] r_ovf_cnt;

  assign w_out_xfer = o_valid & i_ready;
  assign o_ovf_cnt  = r_ovf_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ovf_cnt <= '0;
    end else if (i_cnt_clr) begin
      r_ovf_cnt <= '0;
    end else if (w_out_xfer && o_ovf && (r_ovf_cnt != {CNT_W{1'b1}})) begin
      r_ovf_cnt <= r_ovf_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fx_sub_pipe.sv
// Self-checking bench for fx_sub_pipe (IN 15.8, OUT 12.6, LAT 2, CNT_W 16).
// Honours FX_SUB_SAT_EN for the expected overflow data.
module tb_fx_sub_pipe;

  localparam int LAT = 2;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [14:0] i_data_1;
  logic [14:0] i_data_2;
  logic        o_valid;
  logic        i_ready;
  logic [11:0] o_data;
  logic        o_ovf;
  logic [15:0] o_ovf_cnt;
  logic        i_cnt_clr;

  fx_sub_pipe dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_data_1  (i_data_1),
    .i_data_2  (i_data_2),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_data    (o_data),
    .o_ovf     (o_ovf),
    .o_ovf_cnt (o_ovf_cnt),
    .i_cnt_clr (i_cnt_clr)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [11:0] d;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic [14:0] a;
    logic [14:0] b;
    logic [11:0] d_wrap;
    logic [11:0] d_sat;
    logic        ovf;
  } vec_t;

  int          n_cmp;
  int          n_mis;
  int          rx_cnt;
  exp_t        exp_q[$];
  logic [15:0] m_cnt;
  logic        prev_stall;
  logic [11:0] prev_d;
  logic        prev_ovf;
  logic        s_o_ready;
  logic        s_o_valid;
  logic        s_xfer_out;
  logic        s_acc;
  logic [15:0] s_cnt;
  vec_t        tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: exact integer difference, floor division by 2^(8-6),
  // range test on a 12-bit signed word, then clamp or modulo 4096.
  function automatic exp_t model(input logic [14:0] a, input logic [14:0] b);
    exp_t r;
    int   ai;
    int   bi;
    int   diff;
    int   q;
    ai    = int'($signed(a));
    bi    = int'($signed(b));
    diff  = ai - bi;
    q     = (diff >= 0) ? diff / 4 : -((-diff + 3) / 4);
    r.ovf = (q > 2047) || (q < -2048);
`ifdef FX_SUB_SAT_EN
    if (r.ovf) r.d = (q < 0) ? 12'h800 : 12'h7FF;
    else       r.d = 12'(((q % 4096) + 4096) % 4096);
`else
    r.d = 12'(((q % 4096) + 4096) % 4096);
`endif
    return r;
  endfunction

  // One clock: sample at the falling edge, score, then step past the rising edge.
  task automatic cycle();
    exp_t e;
    logic popped_ovf;
    popped_ovf = 1'b0;
    @(negedge i_clk);
    s_o_ready  = o_ready;
    s_o_valid  = o_valid;
    s_xfer_out = o_valid && i_ready;
    s_acc      = i_valid && o_ready;
    s_cnt      = o_ovf_cnt;
    chk("ovf_cnt", 32'(o_ovf_cnt), 32'(m_cnt));
    if (prev_stall) begin
      chk("stall_valid", 32'(o_valid), 32'(1));
      chk("stall_data", 32'(o_data), 32'(prev_d));
      chk("stall_ovf", 32'(o_ovf), 32'(prev_ovf));
    end
    if (s_xfer_out) begin
      chk("out_expected", 32'(exp_q.size() != 0), 32'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("out_data", 32'(o_data), 32'(e.d));
        chk("out_ovf", 32'(o_ovf), 32'(e.ovf));
        popped_ovf = e.ovf;
        rx_cnt++;
      end
    end
    if (i_cnt_clr) m_cnt = 16'h0;
    else if (popped_ovf && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'h1;
    prev_stall = o_valid && !i_ready;
    prev_d     = o_data;
    prev_ovf   = o_ovf;
    if (s_acc) exp_q.push_back(model(i_data_1, i_data_2));
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    int n;
    int idx;
    int guard;
    logic seen;
    logic saw_not_ready;
    logic [11:0] r;

    tbl[0] = '{15'h0100, 15'h0080, 12'h020, 12'h020, 1'b0};
    tbl[1] = '{15'h0000, 15'h0001, 12'hFFF, 12'hFFF, 1'b0};
    tbl[2] = '{15'h3FFF, 15'h4000, 12'hFFF, 12'h7FF, 1'b1};
    tbl[3] = '{15'h4000, 15'h3FFF, 12'h000, 12'h800, 1'b1};
    tbl[4] = '{15'h1FFF, 15'h0000, 12'h7FF, 12'h7FF, 1'b0};
    tbl[5] = '{15'h2000, 15'h0000, 12'h800, 12'h7FF, 1'b1};
    tbl[6] = '{15'h6000, 15'h0000, 12'h800, 12'h800, 1'b0};
    tbl[7] = '{15'h0000, 15'h2001, 12'h7FF, 12'h800, 1'b1};
    tbl[8] = '{15'h0005, 15'h0002, 12'h000, 12'h000, 1'b0};
    tbl[9] = '{15'h0000, 15'h0005, 12'hFFE, 12'hFFE, 1'b0};

    n_cmp = 0; n_mis = 0; rx_cnt = 0;
    m_cnt = 16'h0; prev_stall = 1'b0; prev_d = 12'h0; prev_ovf = 1'b0;
    i_rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1; i_cnt_clr = 1'b0;
    i_data_1 = 15'h0; i_data_2 = 15'h0;

    // Reset state
    #2;
    chk("rst_valid", 32'(o_valid), 32'(0));
    chk("rst_data", 32'(o_data), 32'(0));
    chk("rst_ovf", 32'(o_ovf), 32'(0));
    chk("rst_cnt", 32'(o_ovf_cnt), 32'(0));
    #21;
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    chk("ready_after_rst", 32'(o_ready), 32'(1));

    // Single-op table: exact latency and hand-computed results
    for (int t = 0; t < 10; t++) begin
      i_ready  = 1'b1;
      i_valid  = 1'b1;
      i_data_1 = tbl[t].a;
      i_data_2 = tbl[t].b;
      cycle();
      chk("tbl_accept", 32'(s_acc), 32'(1));
      i_valid  = 1'b0;
      i_data_1 = 15'(t * 1234 + 77);
      i_data_2 = 15'(t * 999 + 3);
      n = 0; seen = 1'b0;
      while (!seen && n < 8) begin
        #3;
        if (o_valid) begin
          seen = 1'b1;
`ifdef FX_SUB_SAT_EN
          chk("tbl_data", 32'(o_data), 32'(tbl[t].d_sat));
`else
          chk("tbl_data", 32'(o_data), 32'(tbl[t].d_wrap));
`endif
          chk("tbl_ovf", 32'(o_ovf), 32'(tbl[t].ovf));
        end
        cycle();
        n++;
      end
      chk("tbl_seen", 32'(seen), 32'(1));
      chk("tbl_latency", 32'(n), 32'(LAT));
    end

    // Eight back-to-back ops with output stalled for cycles 3..5
    idx = 0; saw_not_ready = 1'b0; rx_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      i_ready  = !(c >= 3 && c <= 5);
      i_valid  = (idx < 8);
      i_data_1 = 15'(idx * 300 - 900);
      i_data_2 = 15'(idx * 37 + 5);
      cycle();
      if (i_valid && !s_o_ready) saw_not_ready = 1'b1;
      if (s_acc) idx++;
    end
    i_valid = 1'b0;
    chk("burst_accepted", 32'(idx), 32'(8));
    chk("burst_received", 32'(rx_cnt), 32'(8));
    chk("burst_backpressure", 32'(saw_not_ready), 32'(1));
    chk("burst_drained", 32'(exp_q.size()), 32'(0));

    // Reset with two ops in flight
    i_ready  = 1'b1;
    i_valid  = 1'b1;
    i_data_1 = 15'h3FFF; i_data_2 = 15'h4000;
    cycle();
    i_data_1 = 15'h0100; i_data_2 = 15'h0080;
    cycle();
    i_valid = 1'b0;
    chk("inflight_valid", 32'(o_valid), 32'(1));
    i_rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(o_valid), 32'(0));
    chk("midrst_cnt", 32'(o_ovf_cnt), 32'(0));
    chk("midrst_data", 32'(o_data), 32'(0));
    exp_q.delete();
    m_cnt = 16'h0; prev_stall = 1'b0;
    #20;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    chk("ready_after_midrst", 32'(o_ready), 32'(1));
    for (int c = 0; c < 6; c++) begin
      cycle();
      chk("no_stale_valid", 32'(s_o_valid), 32'(0));
    end

    // Randomized traffic against the reference model
    for (int c = 0; c < 3000; c++) begin
      i_valid   = ($urandom_range(0, 3) != 0);
      i_ready   = ($urandom_range(0, 3) != 0);
      i_cnt_clr = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 1) == 1) begin
        i_data_1 = 15'($urandom);
        i_data_2 = 15'($urandom);
      end else begin
        r = 12'($urandom);
        i_data_1 = {{3{r[11]}}, r};
        r = 12'($urandom);
        i_data_2 = {{3{r[11]}}, r};
      end
      cycle();
    end
    i_valid = 1'b0; i_ready = 1'b1; i_cnt_clr = 1'b0;
    for (int c = 0; c < 6; c++) cycle();
    chk("rand_drained", 32'(exp_q.size()), 32'(0));

    // Counter saturation, then clear racing an overflow transfer
    i_ready  = 1'b1;
    i_valid  = 1'b1;
    i_data_1 = 15'h3FFF; i_data_2 = 15'h4000;
    guard = 0;
    while (m_cnt != 16'hFFFF && guard < 70000) begin
      cycle();
      guard++;
    end
    chk("sat_reached_in_budget", 32'(guard < 70000), 32'(1));
    for (int c = 0; c < 5; c++) cycle();
    chk("sat_hold", 32'(o_ovf_cnt), 32'hFFFF);
    i_cnt_clr = 1'b1;
    cycle();
    chk("clr_with_ovf_xfer", 32'(s_xfer_out && o_ovf), 32'(1));
    i_cnt_clr = 1'b0;
    i_valid = 1'b0;
    cycle();
    chk("clr_wins", 32'(s_cnt), 32'(0));
    for (int c = 0; c < 6; c++) cycle();
    chk("final_drained", 32'(exp_q.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
